// File: rtl/dram_bank_req_encoder_if.sv
// Bank request / scheduler handshake bundle for dram_bank_req_encoder.
//
// Signals:
//   en         enables new bank selections
//   req        per-bank request lines (level, held until granted)
//   bank_idx   encoded winning bank index
//   bank_valid bank_idx is valid and awaiting acceptance
//   bank_ready scheduler accepts bank_idx
//   grant      one-hot, one-cycle acknowledge to the winning bank
//   pending    OR of all request lines
//
// Modports:
//   master  requester/scheduler side (drives en, req, bank_ready)
//   slave   encoder side (drives bank_idx, bank_valid, grant, pending)
interface dram_bank_req_encoder_if #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 3
);
  logic                 en;
  logic [NUM_BANKS-1:0] req;
  logic [IDX_W-1:0]     bank_idx;
  logic                 bank_valid;
  logic                 bank_ready;
  logic [NUM_BANKS-1:0] grant;
  logic                 pending;

  modport master (
    output en, req, bank_ready,
    input  bank_idx, bank_valid, grant, pending
  );

  modport slave (
    input  en, req, bank_ready,
    output bank_idx, bank_valid, grant, pending
  );
endinterface

// File: rtl/dram_bank_req_encoder.sv
// Round-robin encoder from eight per-bank request lines to a registered
// 3-bit bank index for the command scheduler.
//
// A selection is made in IDLE, presented with valid/ready in HOLD, and the
// winning bank receives a one-cycle one-hot grant in ACK. The round-robin
// pointer advances to the bank after the one just granted.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    request/handshake bundle (slave modport)
module dram_bank_req_encoder #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dram_bank_req_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     bank_idx_q, bank_idx_d;
  logic                 bank_valid_q, bank_valid_d;
  logic [NUM_BANKS-1:0] grant_q, grant_d;

  logic [IDX_W:0]       rr_sel;

  // Returns {found, index}: first set request scanning p, p+1, ... with
  // natural wrap of the index width. Scanned from the far end so the
  // closest candidate to p is the last one written.
  function automatic logic [IDX_W:0] rr_select(
    input logic [NUM_BANKS-1:0] r,
    input logic [IDX_W-1:0]     p
  );
    logic [IDX_W-1:0] cand;
    logic [IDX_W:0]   res;
    res = '0;
    for (int off = NUM_BANKS - 1; off >= 0; off--) begin
      cand = p + IDX_W'(off);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign rr_sel = rr_select(bus.req, ptr_q);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    bank_idx_d   = bank_idx_q;
    bank_valid_d = bank_valid_q;
    grant_d      = '0;

    unique case (state_q)
      IDLE: begin
        // req is only consulted here, so garbage on it while an index is
        // in flight cannot reach bank_idx.
        if (bus.en && rr_sel[IDX_W]) begin
          bank_idx_d   = rr_sel[IDX_W-1:0];
          bank_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // The held index is committed: en and req no longer matter.
        if (bus.bank_ready) begin
          bank_valid_d = 1'b0;
          grant_d      = NUM_BANKS'(1) << bank_idx_q;
          ptr_d        = bank_idx_q + IDX_W'(1);
          state_d      = ACK;
        end
      end
      ACK: begin
        // Dead cycle so the granted requester can drop its line before
        // the next scan.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        bank_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      bank_idx_q   <= '0;
      bank_valid_q <= 1'b0;
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bank_idx_q   <= bank_idx_d;
      bank_valid_q <= bank_valid_d;
      grant_q      <= grant_d;
    end
  end

  assign bus.bank_idx   = bank_idx_q;
  assign bus.bank_valid = bank_valid_q;
  assign bus.grant      = grant_q;
  assign bus.pending    = |bus.req;

endmodule

// File: tb/tb_dram_bank_req_encoder.sv
module tb_dram_bank_req_encoder;

  logic clk;
  logic rst_n;

  dram_bank_req_encoder_if #(.NUM_BANKS(8), .IDX_W(3)) bus_if ();

  dram_bank_req_encoder #(.NUM_BANKS(8), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding index, grant due, round-robin pointer.
  bit       m_valid;
  int       m_idx;
  logic [7:0] m_grant;
  int       m_ptr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_grant = 8'h00;
    m_ptr   = 0;
  endtask

  task automatic model_edge(input bit e, input logic [7:0] r, input bit rdy);
    if (!rst_n) begin
      model_reset();
    end else if (m_grant != 8'h00) begin
      m_grant = 8'h00;                       // acknowledge cycle over
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        m_grant = 8'h01 << m_idx;
        m_ptr   = (m_idx + 1) % 8;
      end
    end else if (e && r != 8'h00) begin
      m_idx   = ref_pick(r, m_ptr);
      m_valid = 1'b1;
    end
  endtask

  // Called just after a falling edge: drive, let a rising edge pass, check.
  task automatic step(input bit e, input logic [7:0] r, input bit rdy);
    bus_if.en         = e;
    bus_if.req        = r;
    bus_if.bank_ready = rdy;
    @(posedge clk);
    model_edge(e, r, rdy);
    @(negedge clk);
    chk("valid",   32'(bus_if.bank_valid), 32'(m_valid));
    chk("idx",     32'(bus_if.bank_idx),   32'(m_idx));
    chk("grant",   32'(bus_if.grant),      32'(m_grant));
    chk("pending", 32'(bus_if.pending),    32'(|r));
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(bus_if.bank_valid), 32'd0);
    chk("rst_idx",   32'(bus_if.bank_idx),   32'd0);
    chk("rst_grant", 32'(bus_if.grant),      32'd0);
    step(1'b0, 8'h00, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit         e, rdy;
    logic [7:0] r;

    rst_n = 1'b1;
    bus_if.en = 1'b0;
    bus_if.req = 8'h00;
    bus_if.bank_ready = 1'b0;
    model_reset();
    @(negedge clk);
    async_reset();

    // 1: single request, ready high
    step(1'b1, 8'h10, 1'b1);
    chk("t1_valid", 32'(bus_if.bank_valid), 32'd1);
    chk("t1_idx",   32'(bus_if.bank_idx),   32'd4);
    step(1'b1, 8'h10, 1'b1);
    chk("t1_grant", 32'(bus_if.grant), 32'h10);
    step(1'b1, 8'h00, 1'b1);
    chk("t1_grant_off", 32'(bus_if.grant), 32'h00);
    step(1'b1, 8'hFF, 1'b1);
    chk("t1_ptr5", 32'(bus_if.bank_idx), 32'd5);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);

    // 2: all requests held, full rotation from ptr 0
    async_reset();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 8'hFF, 1'b1);
      chk("t2_seq", 32'(bus_if.bank_idx), 32'(k % 8));
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
    end

    // 3: stall in HOLD
    step(1'b1, 8'h04, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h04, 1'b0);
      chk("t3_stall_idx",   32'(bus_if.bank_idx), 32'd2);
      chk("t3_stall_grant", 32'(bus_if.grant),    32'd0);
    end
    step(1'b1, 8'h04, 1'b1);
    chk("t3_grant", 32'(bus_if.grant), 32'h04);
    step(1'b0, 8'h00, 1'b0);

    // 4: en low blocks selection
    async_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h81, 1'b1);
      chk("t4_valid", 32'(bus_if.bank_valid), 32'd0);
    end
    step(1'b1, 8'h81, 1'b1);
    chk("t4_idx", 32'(bus_if.bank_idx), 32'd0);
    step(1'b1, 8'h80, 1'b1);
    step(1'b1, 8'h80, 1'b1);

    // 5: pointer wrap after granting bank 5 (ptr currently 1)
    step(1'b1, 8'h20, 1'b1);
    chk("t5_idx5", 32'(bus_if.bank_idx), 32'd5);
    step(1'b1, 8'h20, 1'b1);
    step(1'b1, 8'h21, 1'b1);
    step(1'b1, 8'h21, 1'b1);
    chk("t5_wrap", 32'(bus_if.bank_idx), 32'd0);
    step(1'b1, 8'h21, 1'b1);
    step(1'b1, 8'h20, 1'b1);
    step(1'b1, 8'h20, 1'b1);
    chk("t5_next", 32'(bus_if.bank_idx), 32'd5);
    step(1'b1, 8'h20, 1'b1);
    step(1'b1, 8'h00, 1'b1);

    // 6: reset while holding bank 3
    async_reset();
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    chk("t6_hold", 32'(bus_if.bank_idx), 32'd3);
    async_reset();
    chk("t6_no_grant", 32'(bus_if.grant), 32'd0);
    step(1'b1, 8'h09, 1'b1);
    chk("t6_idx", 32'(bus_if.bank_idx), 32'd0);
    step(1'b1, 8'h09, 1'b1);
    chk("t6_grant", 32'(bus_if.grant), 32'h01);
    step(1'b1, 8'h08, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset();
      e   = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'h01 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      step(e, r, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
